muldiv_hilo_ctrl: RTL and testbench
===================================

# muldiv_hilo_ctrl

Execute-stage controller that owns the HI/LO architectural registers and sequences all multiply/divide instructions. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX pipeline register and computes products with an internal 2-stage multiplier. It launches divides on the radix-2 iterative divider placed beside it, captures {remainder, quotient} into HI/LO, and generates the EX stall. It also guarantees that the non-abortable divider is drained cleanly on a pipeline flush.

## Interface
- No parameters; widths are fixed at 32-bit operands.
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset; the divider is fed `~resetn`
- op_valid  in  1  EX instruction valid; held stable by the pipeline while stall_out=1
- op  in  3  md_op_t code
- src_a  in  32  rs value (dividend / multiplicand / MTHI-MTLO data)
- src_b  in  32  rt value (divisor / multiplier)
- flush  in  1  kill the current EX instruction and any in-flight multiply/divide
- stall_out  out  1  freeze IF..EX
- hi, lo  out  32 each  architectural HI/LO, registered
- div_valid  out  1  divider start pulse, registered
- div_sign  out  1  1 for DIV
- div_a, div_b  out  32 each  divider operands, registered
- div_stall  in  1  divider busy
- div_result  in  64  {remainder, quotient}; sign-corrected combinationally from live div_a/div_b

## Operation
- **States**: IDLE, DIV_LAUNCH, DIV_WAIT, MUL_WAIT, DRAIN.
- **Acceptance**:
  - An op is accepted only in IDLE with op_valid=1 and flush=0.
  - In DRAIN, MTHI/MTLO are accepted; mul/div ops are held with stall_out=1.
- **MTHI/MTLO**: write hi or lo at the end of the accepting cycle; no stall.
- **MULT/MULTU**:
  - Operands enter mul_pipe2, which sign- or zero-extends them to 33 bits.
  - IDLE→MUL_WAIT with a 1-bit stage counter.
  - {hi, lo} is written with product[63:0] at the end of the second MUL_WAIT cycle, then →IDLE.
- **DIV/DIVU**:
  - In the accepting cycle, latch div_a=src_a, div_b=src_b, div_sign, then →DIV_LAUNCH.
  - DIV_LAUNCH: div_valid=1 for exactly one cycle, then →DIV_WAIT. The divider re-arms if valid stays high, so the pulse must not be held.
  - DIV_WAIT: when div_stall=0, write hi=div_result[63:32] and lo=div_result[31:0], then →IDLE.
  - div_a and div_b must stay unchanged from launch until the capture cycle.
- **Flush**:
  - In IDLE: the op is dropped.
  - In MUL_WAIT: →IDLE with no write.
  - In DIV_LAUNCH: the pulse is still issued, then →DRAIN.
  - In DIV_WAIT: →DRAIN.
  - DRAIN: stall_out=0 and no HI/LO write from the divider. →IDLE when div_stall=0.
- **Simultaneous events**: flush takes priority over capture in the same cycle, so a flush in the capture cycle suppresses the write.
- **Reset values** (any time, including mid-divide): state=IDLE, hi=lo=0, div_valid=0, div_a=div_b=0, div_sign=0, stall_out=0.

## Timing
- **stall_out**:
  - Combinational: IDLE & op_valid & mul/div op & !flush.
  - Also high in DIV_LAUNCH, in DIV_WAIT while div_stall=1, and in the first MUL_WAIT cycle.
  - Also high in DRAIN when a mul/div op is presented.
  - Low in the capture cycle, so the instruction retires on that edge.
- **Divide, accepted in cycle A**:
  - A+1: LAUNCH, div_valid=1.
  - A+2..A+33: divider counts 1..32, div_stall=1.
  - A+34: div_stall=0 and capture. hi/lo are visible in A+35.
  - Total stall is 34 cycles (A..A+33).
- **Multiply, accepted in cycle A**: hi/lo are visible in A+3; stall covers A and A+1.
- **MTHI/MTLO**: the value is visible on the next cycle.

## Configuration
- `MULDIV_DIVZERO_BYPASS_EN` defined:
  - DIV/DIVU with src_b=0 never launches the divider.
  - The op completes in the accepting cycle with hi/lo unchanged and no stall.
- `MULDIV_DIVZERO_BYPASS_EN` undefined:
  - Divide-by-zero runs the full divider sequence.
  - hi/lo receive whatever the divider produces.

## Structure
- Shared package muldiv_pkg holds:
  - md_op_t: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - The state enum.
  - DIV_CYCLES=32.
- One sub-module, mul_pipe2: 33×33 signed multiplier with one input register and one output register.
- The divider is instantiated at the EX top level beside this block, not inside it.

## Test plan
- DIV src_a=0xFFFFFFF9 (-7), src_b=2, accepted in A → stall A..A+33; in A+35 lo=0xFFFFFFFD, hi=0xFFFFFFFF; div_valid high only in A+1.
- DIVU 100/7 → lo=14, hi=2; div_a/div_b remain stable through A+34.
- MULT 0xFFFFFFFF×2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU with the same operands → hi=1, lo=0xFFFFFFFE; both visible 3 cycles after accept.
- Flush in A+10 of a DIV → stall_out drops in A+11; MTLO 0x5 written during DRAIN; a DIVU presented at A+12 is stalled until A+34, then launched; the flushed divide never writes hi/lo.
- DIV x/0:
  - With `MULDIV_DIVZERO_BYPASS_EN` defined → no div_valid, hi/lo unchanged, no stall.
  - With it undefined → 34-cycle stall.
- resetn asserted at A+20 of a DIV → hi=lo=0 and state IDLE immediately; a new DIVU 9/3 after release → lo=3, hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply/divide controller.
//   md_op_t    - EX-stage multiply/divide opcode
//   md_state_t - controller sequencing state
//   DIV_CYCLES - number of busy cycles of the external radix-2 divider
package muldiv_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } md_op_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DIV_LAUNCH = 3'd1,
        DIV_WAIT   = 3'd2,
        MUL_WAIT   = 3'd3,
        DRAIN      = 3'd4
    } md_state_t;

    localparam int DIV_CYCLES = 32;

    function automatic logic is_mul(input md_op_t o);
        return (o == MULT) || (o == MULTU);
    endfunction

    function automatic logic is_div(input md_op_t o);
        return (o == DIV) || (o == DIVU);
    endfunction

endpackage

// File: rtl/mul_pipe2.sv
// mul_pipe2: two-stage 33x33 signed multiplier (input register + output register).
// Ports:
//   clk, resetn     - clock, asynchronous active-low reset
//   load            - capture a/b into the input register
//   is_signed       - 1: sign-extend operands to 33 bits, 0: zero-extend
//   a, b            - 32-bit operands
//   product         - low 64 bits of the 33x33 product, valid two cycles after load
module mul_pipe2 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] product
);

    logic [32:0] a_reg;
    logic [32:0] b_reg;
    logic [63:0] prod_reg;
    logic [63:0] a_ext;
    logic [63:0] b_ext;

    // Only the low 64 bits of the 66-bit product are architecturally visible,
    // and those are identical for a 64-bit multiply of the sign-extended operands.
    assign a_ext = {{31{a_reg[32]}}, a_reg};
    assign b_ext = {{31{b_reg[32]}}, b_reg};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_reg    <= '0;
            b_reg    <= '0;
            prod_reg <= '0;
        end else begin
            if (load) begin
                a_reg <= {is_signed & a[31], a};
                b_reg <= {is_signed & b[31], b};
            end
            prod_reg <= a_ext * b_ext;
        end
    end

    assign product = prod_reg;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: owns HI/LO and sequences MULT/MULTU/DIV/DIVU/MTHI/MTLO in EX.
// Multiplies run on the internal mul_pipe2; divides are launched on an external
// non-abortable radix-2 divider and drained cleanly when flushed.
// Ports:
//   clk, resetn             - clock, asynchronous active-low reset
//   op_valid, op            - EX instruction valid and opcode (held while stalled)
//   src_a, src_b            - rs / rt operands
//   flush                   - kill EX instruction and any in-flight mul/div
//   stall_out               - freeze IF..EX (combinational)
//   hi, lo                  - architectural HI/LO (registered)
//   div_valid               - one-cycle divider start pulse (registered)
//   div_sign, div_a, div_b  - divider operands, stable from launch to capture
//   div_stall, div_result   - divider busy flag and {remainder, quotient}
// Optional feature: define MULDIV_DIVZERO_BYPASS_EN to retire divide-by-zero
// immediately without touching the divider or HI/LO.
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  md_op_t      op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall_out,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_valid,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_stall,
    input  logic [63:0] div_result
);

    md_state_t   state_reg;
    logic        mul_cnt_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] div_a_reg;
    logic [31:0] div_b_reg;
    logic        div_valid_reg;
    logic        div_sign_reg;

    logic [63:0] mul_product;
    logic        accept;
    logic        mt_ok;
    logic        div_zero;
    logic        md_presented;

`ifdef MULDIV_DIVZERO_BYPASS_EN
    assign div_zero = is_div(op) && (src_b == 32'd0);
`else
    assign div_zero = 1'b0;
`endif

    // A mul/div that actually needs the sequencer (bypassed x/0 does not).
    assign md_presented = op_valid && (is_mul(op) || (is_div(op) && !div_zero));
    assign accept       = (state_reg == IDLE) && op_valid && !flush;
    // MTHI/MTLO only touch HI/LO, so they may retire while a flushed divide drains.
    assign mt_ok        = op_valid && !flush && ((state_reg == IDLE) || (state_reg == DRAIN));

    mul_pipe2 u_mul (
        .clk       (clk),
        .resetn    (resetn),
        .load      (accept && is_mul(op)),
        .is_signed (op == MULT),
        .a         (src_a),
        .b         (src_b),
        .product   (mul_product)
    );

    always_comb begin
        stall_out = 1'b0;
        case (state_reg)
            IDLE:       stall_out = md_presented && !flush;
            DIV_LAUNCH: stall_out = 1'b1;
            DIV_WAIT:   stall_out = div_stall;
            MUL_WAIT:   stall_out = !mul_cnt_reg;
            DRAIN:      stall_out = md_presented;
            default:    stall_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            mul_cnt_reg   <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            div_a_reg     <= '0;
            div_b_reg     <= '0;
            div_valid_reg <= 1'b0;
            div_sign_reg  <= 1'b0;
        end else begin
            // Divider re-arms on a held valid, so the start pulse self-clears.
            div_valid_reg <= 1'b0;

            if (mt_ok && (op == MTHI)) hi_reg <= src_a;
            if (mt_ok && (op == MTLO)) lo_reg <= src_a;

            case (state_reg)
                IDLE: begin
                    if (accept && is_mul(op)) begin
                        mul_cnt_reg <= 1'b0;
                        state_reg   <= MUL_WAIT;
                    end else if (accept && is_div(op) && !div_zero) begin
                        div_a_reg     <= src_a;
                        div_b_reg     <= src_b;
                        div_sign_reg  <= (op == DIV);
                        div_valid_reg <= 1'b1;
                        state_reg     <= DIV_LAUNCH;
                    end
                end
                // The pulse is already on the wire; a flush here must still
                // wait for the divider to finish.
                DIV_LAUNCH: state_reg <= flush ? DRAIN : DIV_WAIT;
                DIV_WAIT: begin
                    if (flush) begin
                        state_reg <= DRAIN;
                    end else if (!div_stall) begin
                        hi_reg    <= div_result[63:32];
                        lo_reg    <= div_result[31:0];
                        state_reg <= IDLE;
                    end
                end
                MUL_WAIT: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else if (!mul_cnt_reg) begin
                        mul_cnt_reg <= 1'b1;
                    end else begin
                        hi_reg    <= mul_product[63:32];
                        lo_reg    <= mul_product[31:0];
                        state_reg <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!div_stall) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign hi        = hi_reg;
    assign lo        = lo_reg;
    assign div_valid = div_valid_reg;
    assign div_sign  = div_sign_reg;
    assign div_a     = div_a_reg;
    assign div_b     = div_b_reg;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
module tb_muldiv_hilo_ctrl;
    import muldiv_pkg::*;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    md_op_t      op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall_out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_valid;
    logic        div_sign;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_stall;
    logic [63:0] div_result;

    muldiv_hilo_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .op_valid   (op_valid),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .stall_out  (stall_out),
        .hi         (hi),
        .lo         (lo),
        .div_valid  (div_valid),
        .div_sign   (div_sign),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_stall  (div_stall),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    localparam int MUL_STALL = 2;
    localparam int DIV_STALL = DIV_CYCLES + 2;

    // ---------------- behavioural divider beside the controller ----------------
    // Divide by zero: magnitude quotient all ones, remainder = dividend.
    function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'(a);
            nb = longint'(b);
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    int div_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn)          div_cnt <= 0;
        else if (div_valid)   div_cnt <= DIV_CYCLES;
        else if (div_cnt > 0) div_cnt <= div_cnt - 1;
    end
    assign div_stall  = (div_cnt != 0);
    assign div_result = div_ref(div_sign, div_a, div_b);

    // ---------------- reference model of HI/LO ----------------
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    function automatic logic bypassed(input md_op_t o, input logic [31:0] b);
`ifdef MULDIV_DIVZERO_BYPASS_EN
        return is_div(o) && (b == 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_stall_of(input md_op_t o, input logic [31:0] b);
        if (is_mul(o)) return MUL_STALL;
        if (is_div(o) && !bypassed(o, b)) return DIV_STALL;
        return 0;
    endfunction

    task automatic model_apply(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [63:0] up;
        case (o)
            MTHI: model_hi = a;
            MTLO: model_lo = a;
            MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {model_hi, model_lo} = p;
            end
            MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                {model_hi, model_lo} = up;
            end
            DIV, DIVU: if (!bypassed(o, b)) {model_hi, model_lo} = div_ref(o == DIV, a, b);
            default: ;
        endcase
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int due, input string nm);
        sb_t e;
        e.due = due;
        e.hi  = model_hi;
        e.lo  = model_lo;
        e.nm  = nm;
        sb_q.push_back(e);
    endtask

    int dv_count = 0;
    int dv_last  = -1;

    // Monitor: counts divider pulses and compares HI/LO when each expected
    // result is due to become visible.
    always @(negedge clk) begin
        if (div_valid) begin
            dv_count++;
            dv_last = cyc;
        end
        while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            check({mon_e.nm, " hilo"}, {hi, lo}, {mon_e.hi, mon_e.lo});
        end
    end

    // ---------------- driver ----------------
    task automatic present(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        flush    = 1'b0;
    endtask

    // Waits for retirement of the presented op and checks stall length,
    // divider pulse timing and operand stability; queues the HI/LO expectation.
    task automatic complete(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                            input int exp_stall, input string nm);
        int n, dv0, r;
        logic armed, stable;
        n = 0; armed = 1'b0; stable = 1'b1; dv0 = dv_count;
        forever begin
            @(negedge clk);
            if (div_valid) armed = 1'b1;
            if (armed && (div_a !== a || div_b !== b)) stable = 1'b0;
            if (!stall_out) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL %s timeout: stall_out still 1 after %0d cycles, required release", nm, n);
                break;
            end
        end
        r = cyc;
        check({nm, " stall_len"}, 64'(n), 64'(exp_stall));
        if (is_div(o) && !bypassed(o, b)) begin
            check({nm, " div_valid_count"}, 64'(dv_count - dv0), 64'd1);
            check({nm, " div_valid_cycle"}, 64'(dv_last), 64'(r - (DIV_CYCLES + 1)));
            check({nm, " div_operands_stable"}, {63'd0, stable}, 64'd1);
        end else if (is_div(o)) begin
            check({nm, " no_div_valid"}, 64'(dv_count - dv0), 64'd0);
        end
        model_apply(o, a, b);
        push_exp(r + 1, nm);
        $display("txn %s op=%0d a=%h b=%h stall=%0d exp_hi=%h exp_lo=%h", nm, o, a, b, n, model_hi, model_lo);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op       = NOP;
    endtask

    task automatic run_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b, input string nm);
        present(o, a, b);
        complete(o, a, b, exp_stall_of(o, b), nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    md_op_t rops[6] = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO};

    initial begin
        int a0;
        md_op_t ro;
        logic [31:0] ra, rb;
        resetn   = 1'b0;
        op_valid = 1'b0;
        op       = NOP;
        src_a    = '0;
        src_b    = '0;
        flush    = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset stall_out", 64'(stall_out), 64'd0);
        check("reset div_valid", 64'(div_valid), 64'd0);
        check("reset div_ab", {div_a, div_b}, 64'd0);
        check("reset div_sign", 64'(div_sign), 64'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Directed cases from the test plan
        run_op(MTHI, 32'h1234_5678, 32'd0, "mthi");
        run_op(MTLO, 32'h9ABC_DEF0, 32'd0, "mtlo");
        run_op(DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(DIVU, 32'd100, 32'd7, "divu_100_7");
        run_op(MULT, 32'hFFFF_FFFF, 32'd2, "mult_m1_2");
        run_op(MULTU, 32'hFFFF_FFFF, 32'd2, "multu_ff_2");
        run_op(DIV,  32'h0000_0055, 32'd0, "div_by_zero");
        run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");

        // Flush of an op presented in IDLE: dropped, no stall, HI/LO untouched
        @(posedge clk);
        #1; op_valid = 1'b1; op = MULT; src_a = 32'd3; src_b = 32'd5; flush = 1'b1;
        @(negedge clk);
        check("flush_idle stall_out", 64'(stall_out), 64'd0);
        @(posedge clk);
        #1; op_valid = 1'b0; op = NOP; flush = 1'b0;
        push_exp(cyc + 2, "flush_idle");
        $display("txn flush_idle MULT dropped");

        // Flush during the first MUL_WAIT cycle: no HI/LO write
        present(MULT, 32'd7, 32'd9);
        @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk);
        #1; flush = 1'b0; op_valid = 1'b0; op = NOP;
        @(negedge clk);
        check("flush_mul stall_out", 64'(stall_out), 64'd0);
        push_exp(cyc + 1, "flush_mul");
        $display("txn flush_mul MULT killed in MUL_WAIT");

        // Flush in A+10 of a DIV, MTLO during DRAIN, DIVU held until the drain ends
        present(DIV, 32'h0000_1000, 32'd3);
        a0 = cyc;
        repeat (10) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk);
        #1; flush = 1'b0; op = MTLO; src_a = 32'h5; src_b = 32'd0;
        @(negedge clk);
        check("flush_div stall_drop", 64'(stall_out), 64'd0);
        check("flush_div cycle", 64'(cyc - a0), 64'd11);
        model_apply(MTLO, 32'h5, 32'd0);
        push_exp(cyc + 1, "mtlo_in_drain");
        $display("txn mtlo_in_drain lo=%h", model_lo);
        @(posedge clk);
        #1; op = DIVU; src_a = 32'hDEAD_BEEF; src_b = 32'd1234;
        push_exp(a0 + 35, "drained_div_no_write");
        complete(DIVU, 32'hDEAD_BEEF, 32'd1234, (DIV_STALL - 11) + DIV_STALL, "divu_after_drain");

        // Randomised mix
        for (int i = 0; i < 24; i++) begin
            ro = rops[$urandom_range(0, 5)];
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'hFFFF_FFFF - $urandom_range(0, 5);
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, $sformatf("rand%0d", i));
        end

        // Asynchronous reset in A+20 of a DIV, then DIVU 9/3
        present(DIV, 32'h0001_2345, 32'd5);
        repeat (20) @(posedge clk);
        #1; resetn = 1'b0; op_valid = 1'b0; op = NOP;
        #1;
        check("midreset hi", 64'(hi), 64'd0);
        check("midreset lo", 64'(lo), 64'd0);
        @(negedge clk);
        check("midreset stall_out", 64'(stall_out), 64'd0);
        check("midreset div_valid", 64'(div_valid), 64'd0);
        check("midreset div_ab", {div_a, div_b}, 64'd0);
        model_hi = '0;
        model_lo = '0;
        $display("txn midreset hi/lo cleared");
        @(posedge clk);
        #1 resetn = 1'b1;
        run_op(DIVU, 32'd9, 32'd3, "divu_9_3");

        repeat (4) @(negedge clk);
        check("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
